// File: rtl/display_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared constants and helpers for the multiplexed 4-digit
//               seven-segment scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam logic [3:0] ANODE_OFF  = 4'b1111;

    // A slot is dark when it and every more significant nibble are zero,
    // except the units digit and the decimal-point digit.
    function automatic logic is_blanked(
        input logic [15:0] snap,
        input logic [1:0]  k,
        input logic        blank_lz,
        input logic [1:0]  dot_pos
    );
        logic w_upper_zero;
        w_upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((i >= int'(k)) && (snap[4*i +: 4] != 4'd0)) begin
                w_upper_zero = 1'b0;
            end
        end
        return blank_lz && (k != 2'd0) && (k != dot_pos) && w_upper_zero;
    endfunction

    function automatic logic [3:0] anode_onehot(input logic [1:0] k);
        return ~(4'b0001 << k);
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : display_scanner_if
// Description : Digit data / control in, decoder and anode drive out.
// Revision    : 1.0 - initial release
// ============================================================================
interface display_scanner_if;

    logic [15:0] digits;
    logic        blank_lz;
    logic        enable;
    logic [3:0]  bcd;
    logic        eight;
    logic [3:0]  an;
    logic [1:0]  digit_idx;

    modport master (
        output digits, blank_lz, enable,
        input  bcd, eight, an, digit_idx
    );

    modport slave (
        input  digits, blank_lz, enable,
        output bcd, eight, an, digit_idx
    );

endinterface
`default_nettype wire

// File: rtl/display_scanner_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : refresh_prescaler
// Description : Free-running divider producing one tick per digit slot.
// Revision    : 1.0 - initial release
// ============================================================================
module refresh_prescaler #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int            CW     = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] c_last = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (enable) begin
            if (r_count == c_last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Gated by enable so a disable on the terminal count suppresses the tick.
    assign tick = enable && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : display_scanner
// Description : Time-multiplexes four BCD digits onto one decoder with
//               frame-coherent snapshots and leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scanner
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int DOT_POS     = 3
) (
    input  logic              clk,
    input  logic              reset,
    display_scanner_if.slave  bus
);

    localparam logic [1:0] c_dot = 2'(DOT_POS);

    logic        w_tick;
    logic [1:0]  r_idx;
    logic [15:0] r_snap;
    logic        r_resume;
    logic [3:0]  r_bcd;
    logic [3:0]  r_an;
    logic        r_eight;

    logic [1:0]  w_sel_idx;
    logic [15:0] w_sel_snap;
    logic        w_blank;
    logic        w_update;

    refresh_prescaler #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (bus.enable),
        .tick   (w_tick)
    );

    // Slot to present at the next edge; the snapshot is refreshed only when
    // a tick wraps the index back to digit 0.
    always_comb begin
        w_sel_idx  = r_idx;
        w_sel_snap = r_snap;
        if (w_tick) begin
            w_sel_idx = r_idx + 2'd1;
            if (w_sel_idx == 2'd0) begin
                w_sel_snap = bus.digits;
            end
        end
        w_blank  = is_blanked(w_sel_snap, w_sel_idx, bus.blank_lz, c_dot);
        w_update = w_tick || r_resume;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx    <= 2'd3;
            r_snap   <= 16'h0000;
            r_resume <= 1'b0;
            r_an     <= ANODE_OFF;
            r_bcd    <= BLANK_CODE;
            r_eight  <= 1'b0;
        end else if (!bus.enable) begin
            r_an     <= ANODE_OFF;
            r_bcd    <= BLANK_CODE;
            r_eight  <= 1'b0;
            r_resume <= 1'b1;
        end else if (w_update) begin
            r_idx    <= w_sel_idx;
            r_snap   <= w_sel_snap;
            r_resume <= 1'b0;
            r_an     <= anode_onehot(w_sel_idx);
            r_bcd    <= w_blank ? BLANK_CODE : w_sel_snap[{w_sel_idx, 2'b00} +: 4];
            r_eight  <= !w_blank && (w_sel_idx == c_dot);
        end
    end

    assign bus.bcd       = r_bcd;
    assign bus.eight     = r_eight;
    assign bus.an        = r_an;
    assign bus.digit_idx = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scanner
// Description : Directed plus random stimulus against a slot-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scanner;

    localparam int DIV = 4;
    localparam int DOT = 3;

    logic clk = 1'b0;
    logic reset;

    display_scanner_if dif();

    display_scanner #(
        .REFRESH_DIV (DIV),
        .DOT_POS     (DOT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: cycle position within the slot, slot number, frame snapshot.
    int m_cnt, m_idx, m_snap, m_an, m_bcd, m_eight;
    bit m_resume;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void show(input int k, input bit blz);
        int  upper;
        bit  blank;
        upper   = m_snap >> (4 * k);
        blank   = blz && (k != 0) && (k != DOT) && (upper == 0);
        m_an    = 15 ^ (1 << k);
        m_bcd   = blank ? 15 : (upper % 16);
        m_eight = (!blank && (k == DOT)) ? 1 : 0;
    endfunction

    task automatic step();
        if (reset) begin
            m_cnt = 0; m_idx = 3; m_snap = 0;
            m_an = 15; m_bcd = 15; m_eight = 0; m_resume = 0;
        end else if (!dif.enable) begin
            m_an = 15; m_bcd = 15; m_eight = 0; m_resume = 1;
        end else if (m_cnt == DIV - 1) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % 4;
            if (m_idx == 0) m_snap = int'(dif.digits);
            show(m_idx, dif.blank_lz);
            m_resume = 0;
        end else begin
            m_cnt++;
            if (m_resume) begin
                show(m_idx, dif.blank_lz);
                m_resume = 0;
            end
        end
        @(posedge clk);
        #1;
        check("an",        dif.an,        m_an);
        check("bcd",       dif.bcd,       m_bcd);
        check("eight",     dif.eight,     m_eight);
        check("digit_idx", dif.digit_idx, m_idx);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_idx(input int target);
        int guard;
        guard = 0;
        while ((m_idx != target || m_cnt != 0) && guard < 64) begin
            step();
            guard++;
        end
        check("wait_idx", dif.digit_idx, target);
    endtask

    initial begin
        dif.digits   = 16'h0000;
        dif.blank_lz = 1'b0;
        dif.enable   = 1'b0;
        reset        = 1'b1;
        run(2);

        // Basic frame with no blanking
        reset        = 1'b0;
        dif.enable   = 1'b1;
        dif.digits   = 16'h1234;
        run(20);

        // Input change mid-frame must not tear the current frame
        run_until_idx(1);
        dif.digits = 16'h5678;
        run(24);

        // Leading-zero suppression with the point digit held lit
        dif.digits   = 16'h0005;
        dif.blank_lz = 1'b1;
        run(24);

        // Disable for 10 cycles during slot 2, then resume
        dif.digits = 16'h0042;
        run_until_idx(2);
        step();
        dif.enable = 1'b0;
        run(10);
        dif.enable = 1'b1;
        run(8);

        // Disable coincident with the terminal count
        for (int g = 0; g < 16 && m_cnt != DIV - 1; g++) step();
        dif.enable = 1'b0;
        step();
        dif.enable = 1'b1;
        run(6);

        // Reset in the middle of slot 2
        run_until_idx(2);
        step();
        reset = 1'b1;
        step();
        reset      = 1'b0;
        dif.digits = 16'h9A0B;
        run(12);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 79) == 0);
            dif.enable = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) dif.blank_lz = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 5) == 0)
                dif.digits = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 3)));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
